// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin bus arbiter.
// Holds the FSM state enum and a one-hot to index helper.
package arb_pkg;

  localparam int N_MASTERS_DEF = 3;
  localparam int MW_DEF        = 2;
  localparam int HOLD_DEF      = 2;

  typedef enum logic {
    PARK,
    OWN
  } arb_state_e;

  // Index of the set bit in a one-hot vector of up to 8 bits.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_bus_arbiter_pick.sv
// Rotating-priority encoder: first set req bit at or after start.
// Positions are scanned start, start+1, ... modulo N.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N  = N_MASTERS_DEF,
  parameter int MW = MW_DEF
) (
  input  logic [N-1:0]  req,
  input  logic [MW-1:0] start,
  output logic [N-1:0]  pick,
  output logic          valid
);

  logic found;
  int   j;

  // Walk the ring from start and take the first requester.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(start) + k) % N;
      if (!found && req[j]) begin
        pick[j] = 1'b1;
        found   = 1'b1;
      end
    end
    valid = |req;
  end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin bus arbiter with bounded owner hold and registered master.
// Define RR_BUS_ARBITER_STARVE_MON_EN to enable the starvation monitor.
module rr_bus_arbiter
  import arb_pkg::*;
#(
  parameter int N_MASTERS = N_MASTERS_DEF,
  parameter int MW        = MW_DEF,
  parameter int HOLD      = HOLD_DEF,
  parameter int MAX_WAIT  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_MASTERS-1:0] i_req,
  input  logic                 i_ready,
  output logic [N_MASTERS-1:0] o_grant,
  output logic [MW-1:0]        o_master,
  output logic                 o_starve
);

  localparam int HW = $clog2(HOLD) + 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD - 1);

  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [HW-1:0]        hold_q, hold_d;
  arb_state_e           state_q, state_d;
  logic [MW-1:0]        master_q;
  logic [MW-1:0]        owner;
  logic [MW-1:0]        start;
  logic [N_MASTERS-1:0] pick;
  logic                 pick_valid;
  logic                 own_req;
  logic                 oth_req;

  assign owner   = MW'(onehot_to_idx(8'(grant_q)));
  assign start   = (owner == MW'(N_MASTERS - 1)) ? '0 : owner + 1'b1;
  assign own_req = |(i_req & grant_q);
  assign oth_req = |(i_req & ~grant_q) & pick_valid;

  rr_pick #(
    .N  (N_MASTERS),
    .MW (MW)
  ) u_pick (
    .req   (i_req),
    .start (start),
    .pick  (pick),
    .valid (pick_valid)
  );

  // Next grant, hold count and state.
  always_comb begin
    grant_d = grant_q;
    hold_d  = hold_q;
    state_d = state_q;
    if (i_ready) begin
      if (own_req) begin
        state_d = OWN;
        if (hold_q < HOLD_MAX) begin
          hold_d = hold_q + 1'b1;
        end else begin
          hold_d = '0;
          if (oth_req) grant_d = pick;
        end
      end else if (oth_req) begin
        grant_d = pick;
        hold_d  = '0;
        state_d = OWN;
      end else begin
        hold_d  = '0;
        state_d = PARK;
      end
    end else if (!own_req && oth_req) begin
      grant_d = pick;
      hold_d  = '0;
      state_d = OWN;
    end
  end

  // Arbitration registers; ready commits the owner as master.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      grant_q  <= N_MASTERS'(1);
      hold_q   <= '0;
      state_q  <= PARK;
      master_q <= '0;
    end else begin
      grant_q <= grant_d;
      hold_q  <= hold_d;
      state_q <= state_d;
      if (i_ready) master_q <= owner;
    end
  end

  assign o_grant  = grant_q;
  assign o_master = master_q;

`ifdef RR_BUS_ARBITER_STARVE_MON_EN
  logic [3:0]           wait_cnt [N_MASTERS];
  logic [N_MASTERS-1:0] starve_vec;

  // Per-master saturating wait counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < N_MASTERS; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (i_req[i] && !grant_q[i]) begin
          if (wait_cnt[i] != 4'hf) wait_cnt[i] <= wait_cnt[i] + 4'd1;
        end else begin
          wait_cnt[i] <= '0;
        end
      end
    end
  end

  // Flag any master whose wait reached the threshold.
  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) begin
      starve_vec[i] = (32'(wait_cnt[i]) >= MAX_WAIT);
    end
  end

  assign o_starve = |starve_vec;
`else
  assign o_starve = 1'b0;
`endif

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed bench for rr_bus_arbiter (N=3, HOLD=2, MAX_WAIT=4).
// Starvation expectations follow RR_BUS_ARBITER_STARVE_MON_EN.
module tb_rr_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic       ready;
  logic [2:0] grant;
  logic [1:0] master;
  logic       starve;

  int checks   = 0;
  int failures = 0;

  rr_bus_arbiter #(
    .N_MASTERS (3),
    .MW        (2),
    .HOLD      (2),
    .MAX_WAIT  (4)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_req    (req),
    .i_ready  (ready),
    .o_grant  (grant),
    .o_master (master),
    .o_starve (starve)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

`ifdef RR_BUS_ARBITER_STARVE_MON_EN
  localparam logic MON = 1'b1;
`else
  localparam logic MON = 1'b0;
`endif

  logic [2:0] rr_g [6];
  logic [1:0] rr_m [6];
  logic       st_e [5];

  initial begin
    rr_g = '{3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};
    rr_m = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
    st_e = '{1'b0, 1'b0, 1'b0, MON, MON};

    rst = 1'b1; req = '0; ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_grant", 32'(grant), 32'b001);
    chk("rst_master", 32'(master), 0);
    chk("rst_starve", 32'(starve), 0);
    ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("idle_grant", 32'(grant), 32'b001);
    chk("idle_master", 32'(master), 0);
    chk("idle_starve", 32'(starve), 0);

    do_reset();
    req = 3'b010; ready = 1'b1;
    tick();
    chk("single_g1", 32'(grant), 32'b010);
    chk("single_m1", 32'(master), 0);
    tick();
    chk("single_g2", 32'(grant), 32'b010);
    chk("single_m2", 32'(master), 1);

    do_reset();
    chk("rr_g0", 32'(grant), 32'b001);
    req = 3'b111; ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("rr_g%0d", i + 1), 32'(grant), 32'(rr_g[i]));
      chk($sformatf("rr_m%0d", i + 1), 32'(master), 32'(rr_m[i]));
    end

    do_reset();
    req = 3'b111; ready = 1'b1;
    tick();
    tick();
    chk("frz_pre_g", 32'(grant), 32'b010);
    chk("frz_pre_m", 32'(master), 0);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("frz_g%0d", i), 32'(grant), 32'b010);
      chk($sformatf("frz_m%0d", i), 32'(master), 0);
    end
    ready = 1'b1;
    tick();
    chk("frz_rel_m", 32'(master), 1);
    chk("frz_rel_g", 32'(grant), 32'b010);
    tick();
    chk("pre_rst_g", 32'(grant), 32'b100);
    tick();
    chk("pre_rst_g2", 32'(grant), 32'b100);
    chk("pre_rst_m", 32'(master), 2);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_g", 32'(grant), 32'b001);
    chk("mid_rst_m", 32'(master), 0);
    tick();
    chk("resume_g1", 32'(grant), 32'b001);
    chk("resume_m1", 32'(master), 0);
    tick();
    chk("resume_g2", 32'(grant), 32'b010);

    do_reset();
    req = 3'b010; ready = 1'b0;
    tick();
    chk("nrdy_hand_g", 32'(grant), 32'b010);
    chk("nrdy_hand_m", 32'(master), 0);

    do_reset();
    req = 3'b101; ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("stv_g%0d", i + 1), 32'(grant), 32'b001);
      chk($sformatf("stv_s%0d", i + 1), 32'(starve), 32'(st_e[i]));
    end
    req = 3'b100;
    tick();
    chk("stv_hand_g", 32'(grant), 32'b100);
    chk("stv_hand_s", 32'(starve), 32'(MON));
    tick();
    chk("stv_clr_s", 32'(starve), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
